mmc1_gen2: RTL and testbench

// Parametrised MMC1-family mapper core (SNROM/SUROM/SOROM/SXROM boards) for the cartridge FPGA.

---
 rtl/mmc1_gen2_if.sv | 40 ++++
 rtl/mmc1_gen2.sv | 159 +++++++++++++++
 tb/tb_mmc1_gen2.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmc1_gen2_if.sv
`default_nettype none
//==============================================================================
// Module   : mmc1_gen2_if
// Brief    : CPU/PPU cartridge bus and PRG/CHR memory-controller strobes.
// Revision : 1.0 - initial release
//==============================================================================
interface mmc1_gen2_if #(
    parameter int ADDR_BITS = 22
);
    logic [15:0]          cpu_addr;
    logic                 cpu_rw;
    logic [7:0]           cpu_data_in;
    logic [13:0]          ppu_addr;
    logic                 ppu_rd;
    logic                 ppu_wr;
    logic                 chr_ram;
    logic [ADDR_BITS-1:0] prg_addr;
    logic                 prg_oe;
    logic                 prg_we;
    logic                 wram_ce;
    logic [ADDR_BITS-1:0] chr_addr;
    logic                 chr_ce;
    logic                 chr_oe;
    logic                 chr_we;
    logic                 ciram_ce;
    logic                 ciram_a10;

    modport master (
        output cpu_addr, cpu_rw, cpu_data_in, ppu_addr, ppu_rd, ppu_wr, chr_ram,
        input  prg_addr, prg_oe, prg_we, wram_ce,
        input  chr_addr, chr_ce, chr_oe, chr_we, ciram_ce, ciram_a10
    );

    modport slave (
        input  cpu_addr, cpu_rw, cpu_data_in, ppu_addr, ppu_rd, ppu_wr, chr_ram,
        output prg_addr, prg_oe, prg_we, wram_ce,
        output chr_addr, chr_ce, chr_oe, chr_we, ciram_ce, ciram_a10
    );
endinterface
`default_nettype wire

// File: rtl/mmc1_gen2.sv
`default_nettype none
//==============================================================================
// Module   : mmc1_gen2
// Brief    : MMC1-family mapper core with 512K PRG outer bank, banked/disableable
//            WRAM and the consecutive-write (RMW) filter.
// Revision : 1.0 - initial release
//==============================================================================
module mmc1_gen2 #(
    parameter int ADDR_BITS      = 22,
    parameter int PRG_OUTER_EN   = 1,
    parameter int WRAM_BANK_BITS = 2,
    parameter int WRAM_DIS_EN    = 1
) (
    input  wire logic  m2,
    input  wire logic  reset,
    mmc1_gen2_if.slave bus
);
    localparam logic [4:0] SHIFT_EMPTY  = 5'b10000;
    localparam logic [4:0] CONTROL_INIT = 5'b01100;
    localparam logic [1:0] TGT_CONTROL  = 2'd0;
    localparam logic [1:0] TGT_CHR0     = 2'd1;
    localparam logic [1:0] TGT_CHR1     = 2'd2;
    localparam logic [1:0] TGT_PRG      = 2'd3;

    logic [4:0] shift, control, chr_bank_0, chr_bank_1, prg_bank;
    logic       prev_wr;
    logic [4:0] shift_nxt, control_nxt, chr_bank_0_nxt, chr_bank_1_nxt, prg_bank_nxt;
    logic       prev_wr_nxt;
    logic       reg_wr, accept;
    logic [4:0] shifted;
    logic       unused_data;

    assign reg_wr      = bus.cpu_addr[15] & ~bus.cpu_rw;
    assign accept      = reg_wr & ~prev_wr;
    assign shifted     = {bus.cpu_data_in[0], shift[4:1]};
    assign unused_data = &{1'b0, bus.cpu_data_in[6:1]};

    // State register; everything moves on the falling edge of M2.
    always_ff @(negedge m2) begin
        if (reset) begin
            shift      <= SHIFT_EMPTY;
            control    <= CONTROL_INIT;
            chr_bank_0 <= 5'd0;
            chr_bank_1 <= 5'd0;
            prg_bank   <= 5'd0;
            prev_wr    <= 1'b0;
        end else begin
            shift      <= shift_nxt;
            control    <= control_nxt;
            chr_bank_0 <= chr_bank_0_nxt;
            chr_bank_1 <= chr_bank_1_nxt;
            prg_bank   <= prg_bank_nxt;
            prev_wr    <= prev_wr_nxt;
        end
    end

    // The marker bit reaching shift[0] identifies the fifth write of a sequence.
    always_comb begin
        shift_nxt      = shift;
        control_nxt    = control;
        chr_bank_0_nxt = chr_bank_0;
        chr_bank_1_nxt = chr_bank_1;
        prg_bank_nxt   = prg_bank;
        prev_wr_nxt    = reg_wr;
        if (accept) begin
            if (bus.cpu_data_in[7]) begin
                shift_nxt   = SHIFT_EMPTY;
                control_nxt = control | CONTROL_INIT;
            end else if (shift[0]) begin
                shift_nxt = SHIFT_EMPTY;
                case (bus.cpu_addr[14:13])
                    TGT_CONTROL: control_nxt    = shifted;
                    TGT_CHR0:    chr_bank_0_nxt = shifted;
                    TGT_CHR1:    chr_bank_1_nxt = shifted;
                    TGT_PRG:     prg_bank_nxt   = shifted;
                    default:     shift_nxt      = SHIFT_EMPTY;
                endcase
            end else begin
                shift_nxt = shifted;
            end
        end
    end

    logic       outer;
    logic [1:0] wram_bank;
    logic       wram_dis;

    generate
        if (PRG_OUTER_EN != 0) begin : g_outer
            assign outer = chr_bank_0[4];
        end else begin : g_no_outer
            assign outer = 1'b0;
        end

        if (WRAM_BANK_BITS >= 2) begin : g_wram_bank2
            assign wram_bank = chr_bank_0[3:2];
        end else if (WRAM_BANK_BITS == 1) begin : g_wram_bank1
            assign wram_bank = {1'b0, chr_bank_0[3]};
        end else begin : g_wram_bank0
            assign wram_bank = 2'b00;
        end

        if (WRAM_DIS_EN != 0) begin : g_wram_dis
            assign wram_dis = prg_bank[4];
        end else begin : g_wram_always
            assign wram_dis = 1'b0;
        end
    endgenerate

    logic       window;
    logic       wram_hit;
    logic [3:0] prg_sel;
    logic [4:0] chr_sel;

    always_comb begin
        window   = (bus.cpu_addr[15:13] == 3'b011);
        wram_hit = window & ~wram_dis;

        casez (control[3:2])
            2'b0?:   prg_sel = {prg_bank[3:1], bus.cpu_addr[14]};
            2'b10:   prg_sel = bus.cpu_addr[14] ? prg_bank[3:0] : 4'h0;
            default: prg_sel = bus.cpu_addr[14] ? 4'hF : prg_bank[3:0];
        endcase

        if (window) begin
            bus.prg_addr = ADDR_BITS'({wram_bank, bus.cpu_addr[12:0]});
        end else begin
            bus.prg_addr = ADDR_BITS'({outer, prg_sel, bus.cpu_addr[13:0]});
        end
        bus.wram_ce = wram_hit;
        bus.prg_oe  = bus.cpu_rw & (bus.cpu_addr[15] | wram_hit);
        bus.prg_we  = ~bus.cpu_rw & wram_hit;

        if (bus.chr_ram) begin
            chr_sel = {4'b0000, bus.ppu_addr[12]};
        end else if (control[4]) begin
            chr_sel = bus.ppu_addr[12] ? chr_bank_1 : chr_bank_0;
        end else begin
            chr_sel = {chr_bank_0[4:1], bus.ppu_addr[12]};
        end
        // With the outer PRG bank in use, chr_bank_0[4] belongs to PRG, not CHR.
        if (PRG_OUTER_EN != 0) begin
            chr_sel[4] = 1'b0;
        end
        bus.chr_addr = ADDR_BITS'({chr_sel, bus.ppu_addr[11:0]});
        bus.chr_ce   = ~bus.ppu_addr[13];
        bus.ciram_ce = ~bus.ppu_addr[13];
        bus.chr_oe   = ~bus.ppu_rd;
        bus.chr_we   = bus.chr_ram & ~bus.ppu_wr;

        case (control[1:0])
            2'b00:   bus.ciram_a10 = 1'b0;
            2'b01:   bus.ciram_a10 = 1'b1;
            2'b10:   bus.ciram_a10 = bus.ppu_addr[10];
            default: bus.ciram_a10 = bus.ppu_addr[11];
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_mmc1_gen2.sv
`default_nettype none
//==============================================================================
// Module   : tb_mmc1_gen2
// Brief    : Scoreboard bench for the mmc1_gen2 mapper core.
// Revision : 1.0 - initial release
//==============================================================================
module tb_mmc1_gen2;
    localparam int ADDR_BITS = 22;

    logic m2    = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;

    mmc1_gen2_if #(.ADDR_BITS(ADDR_BITS)) bus ();

    mmc1_gen2 #(
        .ADDR_BITS     (ADDR_BITS),
        .PRG_OUTER_EN  (1),
        .WRAM_BANK_BITS(2),
        .WRAM_DIS_EN   (1)
    ) dut (
        .m2   (m2),
        .reset(reset),
        .bus  (bus)
    );

    always #10 m2 = ~m2;

    typedef struct {
        string       name;
        logic [21:0] addr;
        logic        oe;
        logic        we;
        logic        wce;
    } prg_exp_t;

    typedef struct {
        string       name;
        logic [21:0] addr;
        logic        ce;
        logic        oe;
        logic        we;
        logic        a10;
    } chr_exp_t;

    prg_exp_t prg_q[$];
    chr_exp_t chr_q[$];

    task automatic cpu_cycle(input logic [15:0] addr, input logic rw, input logic [7:0] data);
        @(posedge m2);
        bus.cpu_addr    = addr;
        bus.cpu_rw      = rw;
        bus.cpu_data_in = data;
    endtask

    task automatic write_reg(input logic [15:0] addr, input logic [4:0] value);
        for (int i = 0; i < 5; i++) begin
            cpu_cycle(addr, 1'b0, {7'd0, value[i]});
            cpu_cycle(16'h0000, 1'b1, 8'h00);
        end
    endtask

    task automatic prg_drive(input string name, input logic [15:0] addr, input logic rw,
                             input logic [21:0] e_addr, input logic e_oe, input logic e_we,
                             input logic e_wce);
        prg_exp_t e;
        cpu_cycle(addr, rw, 8'h00);
        e.name = name; e.addr = e_addr; e.oe = e_oe; e.we = e_we; e.wce = e_wce;
        prg_q.push_back(e);
    endtask

    task automatic chr_drive(input string name, input logic [13:0] paddr, input logic rd_n,
                             input logic wr_n, input logic cram, input logic [21:0] e_addr,
                             input logic e_ce, input logic e_oe, input logic e_we, input logic e_a10);
        chr_exp_t e;
        @(posedge m2);
        bus.ppu_addr = paddr;
        bus.ppu_rd   = rd_n;
        bus.ppu_wr   = wr_n;
        bus.chr_ram  = cram;
        e.name = name; e.addr = e_addr; e.ce = e_ce; e.oe = e_oe; e.we = e_we; e.a10 = e_a10;
        chr_q.push_back(e);
    endtask

    task automatic apply_reset();
        @(posedge m2);
        reset = 1'b1;
        bus.cpu_addr = 16'h0000; bus.cpu_rw = 1'b1; bus.cpu_data_in = 8'h00;
        repeat (2) @(posedge m2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        prg_exp_t e;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       prg_drive("reset_rd_c000", 16'hC000, 1'b1, 22'h3C000, 1'b1, 1'b0, 1'b0);
                1:       prg_drive("reset_rd_8000", 16'h8000, 1'b1, 22'h00000, 1'b1, 1'b0, 1'b0);
                default: prg_drive("reset_rd_6000", 16'h6000, 1'b1, 22'h00000, 1'b1, 1'b0, 1'b1);
            endcase
            #1;
            e = prg_q.pop_front();
            total++;
            if ({bus.prg_addr, bus.prg_oe, bus.prg_we, bus.wram_ce} !== {e.addr, e.oe, e.we, e.wce})
                $display("FAIL %s: got addr=%h oe=%b we=%b wram_ce=%b, want addr=%h oe=%b we=%b wram_ce=%b",
                         e.name, bus.prg_addr, bus.prg_oe, bus.prg_we, bus.wram_ce, e.addr, e.oe, e.we, e.wce);
            else passed++;
        end
    endtask

    task automatic test_prg_bank();
        prg_exp_t e;
        write_reg(16'hE000, 5'd5);
        for (int i = 0; i < 2; i++) begin
            if (i == 0) prg_drive("prg5_rd_8000", 16'h8000, 1'b1, 22'h14000, 1'b1, 1'b0, 1'b0);
            else        prg_drive("prg5_rd_c000", 16'hC000, 1'b1, 22'h3C000, 1'b1, 1'b0, 1'b0);
            #1;
            e = prg_q.pop_front();
            total++;
            if ({bus.prg_addr, bus.prg_oe} !== {e.addr, e.oe})
                $display("FAIL %s: got addr=%h oe=%b, want addr=%h oe=%b",
                         e.name, bus.prg_addr, bus.prg_oe, e.addr, e.oe);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        prg_exp_t e;
        write_reg(16'h8000, 5'b00000);
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: prg_drive("m32k_rd_c000", 16'hC000, 1'b1, 22'h14000, 1'b1, 1'b0, 1'b0);
                1: prg_drive("m32k_rd_8000", 16'h8000, 1'b1, 22'h10000, 1'b1, 1'b0, 1'b0);
                2: begin
                    cpu_cycle(16'hE000, 1'b0, 8'h01);
                    cpu_cycle(16'h0000, 1'b1, 8'h00);
                    cpu_cycle(16'hE000, 1'b0, 8'h01);
                    cpu_cycle(16'h0000, 1'b1, 8'h00);
                    cpu_cycle(16'h8000, 1'b0, 8'h80);
                    cpu_cycle(16'h8000, 1'b0, 8'h00);
                    cpu_cycle(16'h0000, 1'b1, 8'h00);
                    prg_drive("rmw_rd_c000", 16'hC000, 1'b1, 22'h3C000, 1'b1, 1'b0, 1'b0);
                end
                default: begin
                    write_reg(16'hE000, 5'd3);
                    prg_drive("rmw_prg3_8000", 16'h8000, 1'b1, 22'h0C000, 1'b1, 1'b0, 1'b0);
                end
            endcase
            #1;
            e = prg_q.pop_front();
            total++;
            if ({bus.prg_addr, bus.prg_oe} !== {e.addr, e.oe})
                $display("FAIL %s: got addr=%h oe=%b, want addr=%h oe=%b",
                         e.name, bus.prg_addr, bus.prg_oe, e.addr, e.oe);
            else passed++;
        end
    endtask

    task automatic test_outer_wram();
        prg_exp_t e;
        chr_exp_t c;
        write_reg(16'hA000, 5'b11100);
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       prg_drive("outer_rd_c000", 16'hC000, 1'b1, 22'h7C000, 1'b1, 1'b0, 1'b0);
                1:       prg_drive("outer_rd_8000", 16'h8000, 1'b1, 22'h4C000, 1'b1, 1'b0, 1'b0);
                default: prg_drive("wram_wr_6000",  16'h6000, 1'b0, 22'h06000, 1'b0, 1'b1, 1'b1);
            endcase
            #1;
            e = prg_q.pop_front();
            total++;
            if ({bus.prg_addr, bus.prg_oe, bus.prg_we, bus.wram_ce} !== {e.addr, e.oe, e.we, e.wce})
                $display("FAIL %s: got addr=%h oe=%b we=%b wram_ce=%b, want addr=%h oe=%b we=%b wram_ce=%b",
                         e.name, bus.prg_addr, bus.prg_oe, bus.prg_we, bus.wram_ce, e.addr, e.oe, e.we, e.wce);
            else passed++;
        end
        chr_drive("outer_chr_1000", 14'h1000, 1'b0, 1'b1, 1'b0, 22'h0D000, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        c = chr_q.pop_front();
        total++;
        if ({bus.chr_addr, bus.chr_ce, bus.chr_oe, bus.chr_we, bus.ciram_a10} !== {c.addr, c.ce, c.oe, c.we, c.a10})
            $display("FAIL %s: got addr=%h ce=%b oe=%b we=%b a10=%b, want addr=%h ce=%b oe=%b we=%b a10=%b",
                     c.name, bus.chr_addr, bus.chr_ce, bus.chr_oe, bus.chr_we, bus.ciram_a10,
                     c.addr, c.ce, c.oe, c.we, c.a10);
        else passed++;
    endtask

    task automatic test_wram_disable();
        prg_exp_t e;
        write_reg(16'hE000, 5'b10000);
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: prg_drive("wdis_rd_6000", 16'h6000, 1'b1, 22'h06000, 1'b0, 1'b0, 1'b0);
                1: prg_drive("wdis_wr_7fff", 16'h7FFF, 1'b0, 22'h07FFF, 1'b0, 1'b0, 1'b0);
                2: prg_drive("wdis_rd_8000", 16'h8000, 1'b1, 22'h40000, 1'b1, 1'b0, 1'b0);
                default: prg_drive("wdis_rd_c000", 16'hC000, 1'b1, 22'h7C000, 1'b1, 1'b0, 1'b0);
            endcase
            #1;
            e = prg_q.pop_front();
            total++;
            if ({bus.prg_addr, bus.prg_oe, bus.prg_we, bus.wram_ce} !== {e.addr, e.oe, e.we, e.wce})
                $display("FAIL %s: got addr=%h oe=%b we=%b wram_ce=%b, want addr=%h oe=%b we=%b wram_ce=%b",
                         e.name, bus.prg_addr, bus.prg_oe, bus.prg_we, bus.wram_ce, e.addr, e.oe, e.we, e.wce);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        prg_exp_t e;
        logic [4:0] value;
        value = 5'b00110;
        for (int i = 0; i < 3; i++) begin
            cpu_cycle(16'hE000, 1'b0, 8'h01);
            cpu_cycle(16'h0000, 1'b1, 8'h00);
        end
        @(posedge m2);
        reset = 1'b1;
        cpu_cycle(16'hE000, 1'b0, 8'h01);
        @(posedge m2);
        reset = 1'b0;
        bus.cpu_addr = 16'hE000; bus.cpu_rw = 1'b0; bus.cpu_data_in = {7'd0, value[0]};
        cpu_cycle(16'h0000, 1'b1, 8'h00);
        for (int i = 1; i < 5; i++) begin
            cpu_cycle(16'hE000, 1'b0, {7'd0, value[i]});
            cpu_cycle(16'h0000, 1'b1, 8'h00);
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 0) prg_drive("rstmid_rd_8000", 16'h8000, 1'b1, 22'h18000, 1'b1, 1'b0, 1'b0);
            else        prg_drive("rstmid_rd_c000", 16'hC000, 1'b1, 22'h3C000, 1'b1, 1'b0, 1'b0);
            #1;
            e = prg_q.pop_front();
            total++;
            if ({bus.prg_addr, bus.prg_oe} !== {e.addr, e.oe})
                $display("FAIL %s: got addr=%h oe=%b, want addr=%h oe=%b",
                         e.name, bus.prg_addr, bus.prg_oe, e.addr, e.oe);
            else passed++;
        end
    endtask

    task automatic test_mirroring_chr();
        chr_exp_t c;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: begin
                    write_reg(16'h8000, 5'b00010);
                    chr_drive("mir2_0400", 14'h0400, 1'b0, 1'b1, 1'b0, 22'h00400, 1'b1, 1'b1, 1'b0, 1'b1);
                end
                1: chr_drive("mir2_0800", 14'h0800, 1'b0, 1'b1, 1'b0, 22'h00800, 1'b1, 1'b1, 1'b0, 1'b0);
                2: begin
                    write_reg(16'h8000, 5'b10011);
                    write_reg(16'hC000, 5'b00111);
                    chr_drive("mir3_0800", 14'h0800, 1'b0, 1'b1, 1'b0, 22'h00800, 1'b1, 1'b1, 1'b0, 1'b1);
                end
                3: chr_drive("mir3_0400", 14'h0400, 1'b0, 1'b1, 1'b0, 22'h00400, 1'b1, 1'b1, 1'b0, 1'b0);
                4: chr_drive("chr4k_1234", 14'h1234, 1'b0, 1'b1, 1'b0, 22'h07234, 1'b1, 1'b1, 1'b0, 1'b0);
                5: chr_drive("rom_no_we", 14'h0000, 1'b1, 1'b0, 1'b0, 22'h00000, 1'b1, 1'b0, 1'b0, 1'b0);
                6: chr_drive("cram_wr_0000", 14'h0000, 1'b1, 1'b0, 1'b1, 22'h00000, 1'b1, 1'b0, 1'b1, 1'b0);
                7: chr_drive("cram_rd_1234", 14'h1234, 1'b0, 1'b1, 1'b1, 22'h01234, 1'b1, 1'b1, 1'b0, 1'b0);
                8: chr_drive("nt_2c00", 14'h2C00, 1'b0, 1'b1, 1'b1, 22'h00C00, 1'b0, 1'b1, 1'b0, 1'b1);
                default: begin
                    write_reg(16'h8000, 5'b00001);
                    chr_drive("mir1_0000", 14'h0000, 1'b0, 1'b1, 1'b0, 22'h00000, 1'b1, 1'b1, 1'b0, 1'b1);
                end
            endcase
            #1;
            c = chr_q.pop_front();
            total++;
            if ({bus.chr_addr, bus.chr_ce, bus.ciram_ce, bus.chr_oe, bus.chr_we, bus.ciram_a10} !==
                {c.addr, c.ce, c.ce, c.oe, c.we, c.a10})
                $display("FAIL %s: got addr=%h ce=%b ciram_ce=%b oe=%b we=%b a10=%b, want addr=%h ce=%b oe=%b we=%b a10=%b",
                         c.name, bus.chr_addr, bus.chr_ce, bus.ciram_ce, bus.chr_oe, bus.chr_we,
                         bus.ciram_a10, c.addr, c.ce, c.oe, c.we, c.a10);
            else passed++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_addr    = 16'h0000;
        bus.cpu_rw      = 1'b1;
        bus.cpu_data_in = 8'h00;
        bus.ppu_addr    = 14'h0000;
        bus.ppu_rd      = 1'b1;
        bus.ppu_wr      = 1'b1;
        bus.chr_ram     = 1'b0;
        test_reset();
        test_prg_bank();
        test_back_to_back();
        test_outer_wram();
        test_wram_disable();
        test_reset_mid();
        test_mirroring_chr();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
